// File: rtl/rvr32_mem_resp.sv
// rvr32_mem_resp: single-port 32-bit RAM slave behind a valid/ready memory
// interface with a programmable number of wait cycles and window decode.
module rvr32_mem_resp #(
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_valid,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
   output logic        access_err
);

   localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
   localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
   localparam logic [32:0] WIN_BYTES = 33'd1 << (ADDR_WIDTH + 2);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

   state_e                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic [31:0]             addr_q, wdata_q;
   logic [3:0]              wstrb_q;
   logic [31:0]             rdata_q;

   logic                    accept;
   logic                    enter_resp;
   logic                    do_write;
   logic [31:0]             dec_addr;
   logic [3:0]              dec_wstrb;
   logic [31:0]             offset;
   logic                    in_win;
   logic [ADDR_WIDTH-1:0]   word_idx;

   logic [31:0]             ram_q [DEPTH];

   // When WAIT_CYCLES is 0 RESP is entered on the acceptance edge itself, so the
   // decoder must look at the live request in IDLE and the latched one afterwards.
   always_comb begin
      dec_addr  = (state_q == S_IDLE) ? mem_addr  : addr_q;
      dec_wstrb = (state_q == S_IDLE) ? mem_wstrb : wstrb_q;
      offset    = dec_addr - BASE_ADDR;
      in_win    = ({1'b0, offset} < WIN_BYTES);
      word_idx  = offset[ADDR_WIDTH+1:2];
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic: accept, count down wait cycles, abort on dropped valid
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (mem_valid) begin
               accept  = 1'b1;
               cnt_d   = WAIT_INIT;
               state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
            end
         end
         S_WAIT: begin
            if (!mem_valid) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_d = S_RESP;
               end
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
      enter_resp = (state_d == S_RESP);
   end

   // Output logic: response strobe and window error, only while RESP and valid
   always_comb begin
      mem_ready  = (state_q == S_RESP) && mem_valid;
      access_err = mem_ready && !in_win;
      do_write   = mem_ready && in_win && (wstrb_q != '0);
      mem_rdata  = rdata_q;
   end

   // Request latch and read-data register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         rdata_q <= '0;
      end else begin
         if (accept) begin
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            wstrb_q <= mem_wstrb;
         end
         if (enter_resp) begin
            rdata_q <= (in_win && (dec_wstrb == '0)) ? ram_q[word_idx] : '0;
         end
      end
   end

   // RAM byte-lane write on the RESP exit edge; contents survive reset
   always_ff @(posedge clk) begin
      if (do_write) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (wstrb_q[i]) begin
               ram_q[word_idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_rvr32_mem_resp.sv
// Scoreboard bench: dut index 0 runs WAIT_CYCLES=1, dut index 1 WAIT_CYCLES=0.
module tb_rvr32_mem_resp;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [1:0]       valid;
   logic [1:0][31:0] addr;
   logic [1:0][31:0] wdata;
   logic [1:0][3:0]  wstrb;
   logic [1:0]       ready;
   logic [1:0]       err;
   logic [1:0][31:0] rdata;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int unsigned cyc;
   } exp_t;

   exp_t        q0[$];
   exp_t        q1[$];
   int unsigned cyc   = 0;
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   rvr32_mem_resp #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(1)) dut_w1 (
      .clk(clk), .rst_n(rst_n), .mem_valid(valid[0]), .mem_addr(addr[0]),
      .mem_wdata(wdata[0]), .mem_wstrb(wstrb[0]), .mem_ready(ready[0]),
      .mem_rdata(rdata[0]), .access_err(err[0]));

   rvr32_mem_resp #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(0)) dut_w0 (
      .clk(clk), .rst_n(rst_n), .mem_valid(valid[1]), .mem_addr(addr[1]),
      .mem_wdata(wdata[1]), .mem_wstrb(wstrb[1]), .mem_ready(ready[1]),
      .mem_rdata(rdata[1]), .access_err(err[1]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int unsigned wc(input int d);
      return (d == 0) ? 1 : 0;
   endfunction

   // Monitor: every response strobe consumes one expectation of that dut
   always @(negedge clk) begin
      exp_t e;
      for (int d = 0; d < 2; d++) begin
         if (rst_n && (ready[d] || err[d])) begin
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_ready dut%0d: got ready=%0b err=%0b expected none", d, ready[d], err[d]);
            end else begin
               if (d == 0) e = q0.pop_front();
               else        e = q1.pop_front();
               chk($sformatf("ready_dut%0d", d), {31'd0, ready[d]}, 32'd1);
               chk($sformatf("rdata_dut%0d", d), rdata[d], e.rdata);
               chk($sformatf("access_err_dut%0d", d), {31'd0, err[d]}, {31'd0, e.err});
               chk($sformatf("latency_dut%0d", d), cyc, e.cyc);
            end
         end
      end
   end

   // Issue one request (called just after a rising edge with the dut idle)
   task automatic txn(input int d, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input logic [31:0] er, input logic ee,
                      input bit hold);
      exp_t e;
      int   n;
      addr[d]  = a;
      wdata[d] = wd;
      wstrb[d] = st;
      valid[d] = 1'b1;
      e.rdata  = er;
      e.err    = ee;
      e.cyc    = cyc + 1 + wc(d);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
      @(posedge clk); #1;
      addr[d]  = ~a;
      wdata[d] = ~wd;
      wstrb[d] = ~st;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ready[d] && n < 40);
      if (!ready[d]) begin
         n_cmp++;
         n_bad++;
         $display("FAIL ready_timeout dut%0d addr %h: got no ready expected ready", d, a);
         if (d == 0) void'(q0.pop_back());
         else        void'(q1.pop_back());
      end
      @(posedge clk); #1;
      if (!hold) valid[d] = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      valid = '0;
      addr  = '0;
      wdata = '0;
      wstrb = '0;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("reset_ready_dut%0d", d), {31'd0, ready[d]}, 32'd0);
         chk($sformatf("reset_err_dut%0d", d), {31'd0, err[d]}, 32'd0);
         chk($sformatf("reset_rdata_dut%0d", d), rdata[d], 32'd0);
      end
      rst_n = 1'b1;

      // full write / read, then partial byte write
      txn(0, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 1'b0);
      txn(0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b0);
      txn(0, 32'h10, 32'h000055AA, 4'b0011, 32'h0, 1'b0, 1'b0);
      txn(0, 32'h10, 32'h0, 4'h0, 32'hDEAD55AA, 1'b0, 1'b0);
      txn(0, 32'h13, 32'h0, 4'h0, 32'hDEAD55AA, 1'b0, 1'b0);

      // window boundaries
      txn(0, 32'hFFC, 32'h76543210, 4'hF, 32'h0, 1'b0, 1'b0);
      txn(0, 32'hFFC, 32'h0, 4'h0, 32'h76543210, 1'b0, 1'b0);
      txn(0, 32'h0, 32'h0BADCAFE, 4'hF, 32'h0, 1'b0, 1'b0);
      txn(0, 32'h0, 32'h0, 4'h0, 32'h0BADCAFE, 1'b0, 1'b0);
      txn(0, 32'h1000, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 1'b0);
      txn(0, 32'h0, 32'h0, 4'h0, 32'h0BADCAFE, 1'b0, 1'b0);
      txn(0, 32'h1000, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0);
      txn(0, 32'h0, 32'h0, 4'h0, 32'h0BADCAFE, 1'b0, 1'b0);

      // abort in WAIT: no response, no write
      txn(0, 32'h20, 32'hAAAA5555, 4'hF, 32'h0, 1'b0, 1'b0);
      addr[0]  = 32'h20;
      wdata[0] = 32'h12345678;
      wstrb[0] = 4'hF;
      valid[0] = 1'b1;
      @(posedge clk); #1;
      valid[0] = 1'b0;
      @(posedge clk); #1;
      txn(0, 32'h20, 32'h0, 4'h0, 32'hAAAA5555, 1'b0, 1'b0);

      // reset during WAIT of a write
      txn(0, 32'h40, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 1'b0);
      txn(0, 32'h40, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 1'b0);
      addr[0]  = 32'h40;
      wdata[0] = 32'h11111111;
      wstrb[0] = 4'hF;
      valid[0] = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("midreset_ready", {31'd0, ready[0]}, 32'd0);
      chk("midreset_rdata", rdata[0], 32'd0);
      valid[0] = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      txn(0, 32'h40, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 1'b0);

      // zero-wait dut, valid held across back-to-back accesses
      txn(1, 32'h0, 32'h11111111, 4'hF, 32'h0, 1'b0, 1'b1);
      txn(1, 32'h4, 32'h22222222, 4'hF, 32'h0, 1'b0, 1'b1);
      txn(1, 32'h8, 32'h33333333, 4'hF, 32'h0, 1'b0, 1'b1);
      txn(1, 32'hC, 32'h44444444, 4'hF, 32'h0, 1'b0, 1'b1);
      txn(1, 32'h0, 32'h0, 4'h0, 32'h11111111, 1'b0, 1'b1);
      txn(1, 32'h4, 32'h0, 4'h0, 32'h22222222, 1'b0, 1'b1);
      txn(1, 32'h8, 32'h0, 4'h0, 32'h33333333, 1'b0, 1'b1);
      txn(1, 32'hC, 32'h0, 4'h0, 32'h44444444, 1'b0, 1'b0);

      repeat (5) @(posedge clk);
      #1;
      chk("q0_drained", q0.size(), 32'd0);
      chk("q1_drained", q1.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rvr32_mem_resp.md
RVR32_MEM_RESP -- requirements
Module: rvr32_mem_resp

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, word-address bits of internal RAM (2^ADDR_WIDTH x 32-bit words).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte base address of RAM window (aligned to window size).
REQ-003 SHALL have parameter WAIT_CYCLES, default 1, extra wait cycles per access, legal 0..15.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port mem_valid  input  1  request valid; initiator holds it high until mem_ready.
REQ-007 SHALL have port mem_addr  input  32  byte address; bits [1:0] ignored.
REQ-008 SHALL have port mem_wdata  input  32  write data.
REQ-009 SHALL have port mem_wstrb  input  4  byte enables; 4'b0000 = read, nonzero = write.
REQ-010 SHALL have port mem_ready  output  1  one-cycle response strobe.
REQ-011 SHALL have port mem_rdata  output  32  read data, valid while mem_ready high.
REQ-012 SHALL have port access_err  output  1  one-cycle pulse, coincident with mem_ready, for out-of-window access.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-014 SHALL, in IDLE with mem_valid=1 at a rising edge, latch mem_addr, mem_wdata, mem_wstrb; go to WAIT if WAIT_CYCLES>0, else RESP.
REQ-015 SHALL load a wait counter with WAIT_CYCLES on acceptance, decrement once per cycle in WAIT, go to RESP when it reaches 1.
REQ-016 SHALL assert mem_ready = (state==RESP) & mem_valid; first mem_ready is cycle T+1+WAIT_CYCLES after acceptance edge T.
REQ-017 SHALL use only latched request fields after acceptance; mem_addr/wdata/wstrb changes during WAIT/RESP ignored.
REQ-018 SHALL decode in-window as (latched_addr - BASE_ADDR) < 4*2^ADDR_WIDTH; word index = offset[ADDR_WIDTH+1:2].
REQ-019 SHALL, for in-window read, register RAM word into mem_rdata on entry to RESP.
REQ-020 SHALL, for in-window write, update only bytes with wstrb[i]=1 (byte i = bits 8i+7:8i) at the RESP-exit edge, only if mem_valid=1 then; mem_rdata = 0 for writes.
REQ-021 SHALL, for out-of-window access, drop writes, return mem_rdata=0, and assert access_err with mem_ready.
REQ-022 SHALL return from RESP to IDLE unconditionally; at least one IDLE cycle between responses, so max throughput = one access per 2+WAIT_CYCLES cycles.
REQ-023 SHALL abort on mem_valid=0 in WAIT or RESP: return to IDLE, no write, no mem_ready, no access_err.
REQ-024 SHALL hold mem_rdata at last value outside RESP except cleared by write/out-of-window responses and reset.
REQ-025 SHALL never assert mem_ready or access_err in IDLE or WAIT.

Reset
REQ-026 SHALL, on rst_n low (asynchronously, any state, including mid-access): state IDLE, counter 0, mem_ready 0, access_err 0, mem_rdata 0, latched request cleared; pending write discarded.
REQ-027 SHALL not reset RAM contents; accept new requests from first rising edge with rst_n high.

Verification
REQ-028 WAIT_CYCLES=1: write addr 0x10, wdata 0xDEADBEEF, wstrb 4'hF; read 0x10 -> mem_ready high exactly 2 cycles after each acceptance, read mem_rdata=0xDEADBEEF.
REQ-029 Byte write: after REQ-028, write 0x10, wdata 0x000055AA, wstrb 4'b0011; read -> 0xDEAD55AA.
REQ-030 Out of window (ADDR_WIDTH=10, BASE 0): write 0x1000 wstrb 4'hF then read 0x1000 -> mem_ready and access_err pulse together, mem_rdata=0; read 0x0 unchanged.
REQ-031 Abort: start write 0x20 wdata 0x12345678, drop mem_valid in WAIT -> no mem_ready; later read 0x20 returns prior contents.
REQ-032 Reset mid-access: assert rst_n low during WAIT of a write -> mem_ready 0, mem_rdata 0, state IDLE, target word unchanged; next read completes normally.
REQ-033 WAIT_CYCLES=0 back-to-back: mem_valid held, 4 reads -> mem_ready pattern 0,1,0,1,... one response per 2 cycles, no duplicate ready per request.
